mem_or_io: RTL and testbench

Memory/IO data-steering block between the CPU core's execute/writeback path, data memory and the memory-mapped IO peripherals (LEDs, switches). It forwards the effective address, selects the register-file write-back data from memory or IO read data, and drives store data plus the LED/switch chip-selects. The steering datapath is purely combinational. A clocked access checker flags illegal control combinations and address-window mismatches.

---
 rtl/memorio_pkg.sv | 34 +++
 rtl/memorio_access_check.sv | 46 ++++
 rtl/mem_or_io.sv | 59 +++++
 tb/tb_mem_or_io.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/memorio_pkg.sv
// Shared constants, error-code enum and access classifier for the mem_or_io block.
package memorio_pkg;

  localparam int DATA_W = 32;
  localparam int IO_W   = 16;
  localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_RW        = 3'd1,
    ERR_DUAL      = 3'd2,
    ERR_IO_RANGE  = 3'd3,
    ERR_MEM_RANGE = 3'd4
  } err_code_e;

  // Highest-priority illegal condition for one cycle of controls; ERR_NONE if legal.
  function automatic err_code_e access_code(input logic m_read, input logic m_write,
                                            input logic io_read, input logic io_write,
                                            input logic [21:0] addr_hi);
    logic in_io_win;
    in_io_win = (addr_hi == IO_BASE_HI);
    if ((m_read | io_read) & (m_write | io_write))
      return ERR_RW;
    else if ((m_read & io_read) | (m_write & io_write))
      return ERR_DUAL;
    else if ((io_read | io_write) & ~in_io_win)
      return ERR_IO_RANGE;
    else if ((m_read | m_write) & in_io_win)
      return ERR_MEM_RANGE;
    else
      return ERR_NONE;
  endfunction

endpackage

// File: rtl/memorio_access_check.sv
// Sticky access checker: latches the first illegal control/address combination
// seen at a rising clock edge and holds it until reset.
module memorio_access_check
  import memorio_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m_read_i,
  input  logic        m_write_i,
  input  logic        io_read_i,
  input  logic        io_write_i,
  input  logic [21:0] addr_hi_i,
  output logic        err_o,
  output logic [2:0]  err_code_o
);

  logic      err_q, err_d;
  err_code_e code_q, code_d;
  err_code_e cur_code;

  assign cur_code = access_code(m_read_i, m_write_i, io_read_i, io_write_i, addr_hi_i);

  // Only the first error is recorded; later ones leave flag and code untouched.
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (!err_q && (cur_code != ERR_NONE)) begin
      err_d  = 1'b1;
      code_d = cur_code;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: rtl/mem_or_io.sv
// Memory/IO data steering between execute/writeback, data memory and LED/switch IO.
// Optional sticky access checker is built when MEMORIO_ACCESS_CHECK_EN is defined.
module mem_or_io
  import memorio_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              mRead,
  input  logic              mWrite,
  input  logic              ioRead,
  input  logic              ioWrite,
  input  logic [DATA_W-1:0] addr_in,
  output logic [DATA_W-1:0] addr_out,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [IO_W-1:0]   io_rdata,
  input  logic [DATA_W-1:0] r_rdata,
  output logic [DATA_W-1:0] r_wdata,
  output logic [DATA_W-1:0] write_data,
  output logic              LEDCtrl,
  output logic              SwitchCtrl,
  output logic              acc_err,
  output logic [2:0]        acc_err_code
);

  assign addr_out = addr_in;

  // Memory load wins over IO load; IO read data is zero-extended.
  always_comb begin
    r_wdata = '0;
    if (mRead)
      r_wdata = m_rdata;
    else if (ioRead)
      r_wdata = {{(DATA_W-IO_W){1'b0}}, io_rdata};
  end

  assign write_data = (mWrite | ioWrite) ? r_rdata : '0;
  assign LEDCtrl    = ioWrite;
  assign SwitchCtrl = ioRead;

`ifdef MEMORIO_ACCESS_CHECK_EN
  memorio_access_check u_access_check (
    .clk_i      (clock),
    .rst_ni     (rst_n),
    .m_read_i   (mRead),
    .m_write_i  (mWrite),
    .io_read_i  (ioRead),
    .io_write_i (ioWrite),
    .addr_hi_i  (addr_in[31:10]),
    .err_o      (acc_err),
    .err_code_o (acc_err_code)
  );
`else
  logic unused_chk_inputs;
  assign unused_chk_inputs = &{1'b0, clock, rst_n};
  assign acc_err      = 1'b0;
  assign acc_err_code = 3'b000;
`endif

endmodule

// File: tb/tb_mem_or_io.sv
// Directed bench for mem_or_io: datapath vectors plus checker capture/hold/reset.
module tb_mem_or_io;

`ifdef MEMORIO_ACCESS_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst_n;
  logic        mRead, mWrite, ioRead, ioWrite;
  logic [31:0] addr_in, addr_out, m_rdata, r_rdata, r_wdata, write_data;
  logic [15:0] io_rdata;
  logic        LEDCtrl, SwitchCtrl, acc_err;
  logic [2:0]  acc_err_code;

  int checks   = 0;
  int failures = 0;

  // Bench-side model of the sticky checker.
  logic       exp_err;
  logic [2:0] exp_code;

  mem_or_io dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .mRead        (mRead),
    .mWrite       (mWrite),
    .ioRead       (ioRead),
    .ioWrite      (ioWrite),
    .addr_in      (addr_in),
    .addr_out     (addr_out),
    .m_rdata      (m_rdata),
    .io_rdata     (io_rdata),
    .r_rdata      (r_rdata),
    .r_wdata      (r_wdata),
    .write_data   (write_data),
    .LEDCtrl      (LEDCtrl),
    .SwitchCtrl   (SwitchCtrl),
    .acc_err      (acc_err),
    .acc_err_code (acc_err_code)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_code(input logic [3:0] c, input logic [31:0] a);
    logic rd, wr, win;
    rd  = c[3] | c[1];
    wr  = c[2] | c[0];
    win = (a >= 32'hFFFFFC00);
    if (rd & wr)                         return 3'd1;
    if ((c[3] & c[1]) | (c[2] & c[0]))   return 3'd2;
    if ((c[1] | c[0]) & ~win)            return 3'd3;
    if ((c[3] | c[2]) & win)             return 3'd4;
    return 3'd0;
  endfunction

  // controls ordered {mRead, mWrite, ioRead, ioWrite}
  task automatic drive(input logic [3:0] ctrl, input logic [31:0] addr);
    {mRead, mWrite, ioRead, ioWrite} = ctrl;
    addr_in = addr;
    #1;
  endtask

  // One rising edge with model update, then return on the falling edge.
  task automatic tick();
    logic [2:0] c;
    @(posedge clock);
    c = ref_code({mRead, mWrite, ioRead, ioWrite}, addr_in);
    if (CHK_EN && rst_n && !exp_err && (c != 3'd0)) begin
      exp_err  = 1'b1;
      exp_code = c;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err"},  {31'b0, acc_err}, {31'b0, exp_err});
    check({tag, "_code"}, {29'b0, acc_err_code}, {29'b0, exp_code});
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    exp_err  = 1'b0;
    exp_code = 3'd0;
    #1;
    check_err("reset");
    @(negedge clock);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    m_rdata  = 32'hFFFF0001;
    io_rdata = 16'hFFFF;
    r_rdata  = 32'h0F0F0F0F;
    exp_err  = 1'b0;
    exp_code = 3'd0;
    drive(4'b0000, 32'h0);
    do_reset();
    check("idle_rwdata", r_wdata, 32'h0);
    check("idle_wdata",  write_data, 32'h0);
    check("idle_ctrls",  {30'b0, LEDCtrl, SwitchCtrl}, 32'h0);
    tick();
    check_err("idle");

    // memory store
    drive(4'b0100, 32'h4);
    check("mst_wdata", write_data, 32'h0F0F0F0F);
    check("mst_addr",  addr_out, 32'h4);
    check("mst_rwdata", r_wdata, 32'h0);
    check("mst_ctrls", {30'b0, LEDCtrl, SwitchCtrl}, 32'h0);
    tick();
    check_err("mst");

    // IO store
    drive(4'b0001, 32'hFFFFFC60);
    check("iost_wdata", write_data, 32'h0F0F0F0F);
    check("iost_addr",  addr_out, 32'hFFFFFC60);
    check("iost_ctrls", {30'b0, LEDCtrl, SwitchCtrl}, 32'h2);
    tick();
    check_err("iost");

    // memory load
    drive(4'b1000, 32'h4);
    check("mld_rwdata", r_wdata, 32'hFFFF0001);
    check("mld_wdata",  write_data, 32'h0);
    tick();
    check_err("mld");

    // IO load
    drive(4'b0010, 32'hFFFFFC70);
    check("ild_rwdata", r_wdata, 32'h0000FFFF);
    check("ild_ctrls", {30'b0, LEDCtrl, SwitchCtrl}, 32'h1);
    tick();
    check_err("ild");

    // dual read: mRead priority, code 2 captured and held
    drive(4'b1010, 32'h4);
    check("dual_rwdata", r_wdata, 32'hFFFF0001);
    tick();
    check_err("dual");
    drive(4'b0010, 32'h4);
    check("hold_rwdata", r_wdata, 32'h0000FFFF);
    tick();
    check_err("hold");

    // async reset mid-cycle while the IO-range error is still present
    #2;
    rst_n    = 1'b0;
    exp_err  = 1'b0;
    exp_code = 3'd0;
    #1;
    check_err("async");
    check("async_rwdata", r_wdata, 32'h0000FFFF);
    check("async_swctrl", {31'b0, SwitchCtrl}, 32'h1);
    tick();
    check_err("rst_held");
    rst_n = 1'b1;
    tick();
    check_err("post_rst");

    // read+write together -> code 1
    do_reset();
    drive(4'b1001, 32'hFFFFFC00);
    check("rw_rwdata", r_wdata, 32'hFFFF0001);
    check("rw_wdata",  write_data, 32'h0F0F0F0F);
    tick();
    check_err("rw");

    // memory load at the lowest IO address -> code 4
    do_reset();
    drive(4'b1000, 32'hFFFFFC00);
    tick();
    check_err("mem_in_win");

    // IO store just below the window -> code 3
    do_reset();
    drive(4'b0001, 32'hFFFFFBFC);
    tick();
    check_err("io_below_win");

    // dual store -> code 2, then a later code-1 condition must not overwrite
    do_reset();
    drive(4'b0101, 32'hFFFFFFFC);
    tick();
    check_err("dual_st");
    drive(4'b1100, 32'h10);
    tick();
    check_err("no_overwrite");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
